// File: rtl/debug_unit_pkg.sv
// Shared definitions for the host debug controller: command opcodes, FSM states
// and the fixed length of a dump (PC word plus 32 register words, 4 bytes each).
package debug_unit_pkg;

   localparam logic [7:0] DBG_CMD_LOAD = 8'h01;
   localparam logic [7:0] DBG_CMD_RUN  = 8'h02;
   localparam logic [7:0] DBG_CMD_STEP = 8'h03;
   localparam logic [7:0] DBG_CMD_DUMP = 8'h04;
   localparam logic [7:0] DBG_CMD_HALT = 8'h05;

   localparam int DBG_DUMP_LEN = 132;

   typedef enum logic [3:0] {
      IDLE,
      LD_CNT,
      LD_BYTE,
      LD_WR,
      STEP,
      DUMP_PC,
      DUMP_SEL,
      DUMP_CAP,
      DUMP_TX
   } dbg_state_e;

endpackage

// File: rtl/debug_tx_serializer.sv
// Loads one word and emits it as bytes, most significant first, over a
// valid/ready handshake. o_done flags the cycle the final byte is accepted.
module debug_tx_serializer #(
   parameter int NB_BITS = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [NB_BITS-1:0] i_word,
   input  logic               i_tx_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   output logic               o_done
);

   localparam logic [1:0] LAST_IDX = 2'(NB_BITS / 8 - 1);

   logic [NB_BITS-1:0] shift_q, shift_d;
   logic               valid_q, valid_d;
   logic [1:0]         idx_q, idx_d;
   logic               accept;

   assign accept = valid_q && i_tx_ready;

   always_comb begin
      shift_d = shift_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      if (i_load) begin
         shift_d = i_word;
         valid_d = 1'b1;
         idx_d   = '0;
      end else if (accept) begin
         if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
         end else begin
            shift_d = {shift_q[NB_BITS-9:0], 8'h00};
            idx_d   = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shift_q <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
      end
   end

   assign o_tx_data  = shift_q[NB_BITS-1 -: 8];
   assign o_tx_valid = valid_q;
   assign o_done     = accept && (idx_q == LAST_IDX);

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: decodes UART command bytes to load instruction memory,
// run/halt/step the core, and stream the PC plus register file back out.
module debug_unit
   import debug_unit_pkg::*;
#(
   parameter int NB_BITS = 32,
   parameter int NB_REG  = 5,
   parameter int NB_ADDR = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_debug,
   output logic               o_step,
   output logic [NB_ADDR-1:0] o_addr_debug,
   output logic [NB_BITS-1:0] o_data_debug,
   output logic               o_wren_debug,
   output logic [NB_REG-1:0]  o_rfsel_debug,
   input  logic [NB_BITS-1:0] i_rs_debug,
   input  logic [NB_BITS-1:0] i_pc_debug
);

   localparam logic [NB_REG:0] REG_END = {1'b1, {NB_REG{1'b0}}};

   dbg_state_e         state_q, state_d;
   logic               debug_q, debug_d;
   logic               step_q, wren_q;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [NB_BITS-1:0] data_q, data_d;
   logic [NB_REG-1:0]  rfsel_q, rfsel_d;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [8:0]         word_cnt_q, word_cnt_d;
   logic [NB_REG:0]    reg_idx_q, reg_idx_d;
   logic               ser_load, ser_done;
   logic [NB_BITS-1:0] ser_word;

   always_comb begin
      state_d    = state_q;
      debug_d    = debug_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rfsel_d    = rfsel_q;
      byte_idx_d = byte_idx_q;
      word_cnt_d = word_cnt_q;
      reg_idx_d  = reg_idx_q;
      ser_load   = 1'b0;
      ser_word   = i_pc_debug;
      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  DBG_CMD_LOAD: begin
                     debug_d = 1'b1;
                     state_d = LD_CNT;
                  end
                  DBG_CMD_RUN:  debug_d = 1'b0;
                  DBG_CMD_HALT: debug_d = 1'b1;
                  DBG_CMD_STEP: if (debug_q) state_d = STEP;
                  DBG_CMD_DUMP: state_d = DUMP_PC;
                  default: ;
               endcase
            end
         end
         LD_CNT: begin
            if (i_rx_valid) begin
               word_cnt_d = (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
               addr_d     = '0;
               byte_idx_d = '0;
               state_d    = LD_BYTE;
            end
         end
         LD_BYTE: begin
            if (i_rx_valid) begin
               data_d     = {data_q[NB_BITS-9:0], i_rx_data};
               byte_idx_d = byte_idx_q + 1'b1;
               if (byte_idx_q == 2'd3) state_d = LD_WR;
            end
         end
         LD_WR: begin
            addr_d     = addr_q + 1'b1;
            word_cnt_d = word_cnt_q - 1'b1;
            state_d    = (word_cnt_q == 9'd1) ? IDLE : LD_BYTE;
         end
         STEP: state_d = DUMP_PC;
         // Index starts at all-ones so the PC word's completion wraps it to register 0.
         DUMP_PC: begin
            ser_load  = 1'b1;
            ser_word  = i_pc_debug;
            reg_idx_d = '1;
            state_d   = DUMP_TX;
         end
         DUMP_SEL: state_d = DUMP_CAP;
         DUMP_CAP: begin
            ser_load = 1'b1;
            ser_word = i_rs_debug;
            state_d  = DUMP_TX;
         end
         DUMP_TX: begin
            if (ser_done) begin
               reg_idx_d = reg_idx_q + 1'b1;
               if (reg_idx_d == REG_END) begin
                  state_d = IDLE;
               end else begin
                  rfsel_d = reg_idx_d[NB_REG-1:0];
                  state_d = DUMP_SEL;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= IDLE;
         debug_q    <= 1'b1;
         step_q     <= 1'b0;
         wren_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rfsel_q    <= '0;
         byte_idx_q <= '0;
         word_cnt_q <= '0;
         reg_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         debug_q    <= debug_d;
         step_q     <= (state_d == STEP);
         wren_q     <= (state_d == LD_WR);
         addr_q     <= addr_d;
         data_q     <= data_d;
         rfsel_q    <= rfsel_d;
         byte_idx_q <= byte_idx_d;
         word_cnt_q <= word_cnt_d;
         reg_idx_q  <= reg_idx_d;
      end
   end

   debug_tx_serializer #(.NB_BITS(NB_BITS)) u_tx_ser (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (ser_load),
      .i_word     (ser_word),
      .i_tx_ready (i_tx_ready),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .o_done     (ser_done)
   );

   assign o_debug       = debug_q;
   assign o_step        = step_q;
   assign o_wren_debug  = wren_q;
   assign o_addr_debug  = addr_q;
   assign o_data_debug  = data_q;
   assign o_rfsel_debug = rfsel_q;

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: command table, LOAD/DUMP models, handshake stalls and resets.
module tb_debug_unit;
   import debug_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        dbg;
   logic        step;
   logic [9:0]  addr_dbg;
   logic [31:0] data_dbg;
   logic        wren;
   logic [4:0]  rfsel;
   logic [31:0] rs_dbg = 32'h0;
   logic [31:0] pc_val = 32'h0;

   debug_unit #(.NB_BITS(32), .NB_REG(5), .NB_ADDR(10)) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_tx_data     (tx_data),
      .o_tx_valid    (tx_valid),
      .i_tx_ready    (tx_ready),
      .o_debug       (dbg),
      .o_step        (step),
      .o_addr_debug  (addr_dbg),
      .o_data_debug  (data_dbg),
      .o_wren_debug  (wren),
      .o_rfsel_debug (rfsel),
      .i_rs_debug    (rs_dbg),
      .i_pc_debug    (pc_val)
   );

   initial forever #5 clk = ~clk;

   // Simple register file model with one cycle of read latency.
   logic [31:0] regfile [32];
   always @(posedge clk) rs_dbg <= regfile[rfsel];

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = ~tx_ready;
         2: tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
   logic [7:0] tx_q[$];
   wr_t        wr_q[$];
   int         tx_rd = 0;
   int         step_cnt = 0;
   int         stab_bad = 0;
   logic       pend = 1'b0;
   logic [7:0] pend_data = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend <= 1'b0;
      end else begin
         if (pend && (!tx_valid || tx_data != pend_data)) stab_bad <= stab_bad + 1;
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         if (wren) wr_q.push_back({addr_dbg, data_dbg});
         if (step) step_cnt <= step_cnt + 1;
         pend      <= tx_valid && !tx_ready;
         pend_data <= tx_data;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Expected dump: PC then r0..r31, each word MSB first.
   task automatic expect_dump(input string name, input int budget);
      int n;
      logic [31:0] w;
      logic [7:0]  eb;
      int idx;
      n = 0;
      while ((tx_q.size() - tx_rd) < DBG_DUMP_LEN && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      check({name, "_len"}, 64'(tx_q.size() - tx_rd), 64'(DBG_DUMP_LEN));
      for (int i = 0; i < 33; i++) begin
         w = (i == 0) ? pc_val : regfile[i-1];
         for (int b = 0; b < 4; b++) begin
            eb  = w[31-8*b -: 8];
            idx = tx_rd + 4*i + b;
            if (idx < tx_q.size())
               check($sformatf("%s_byte%0d", name, 4*i+b), 64'(tx_q[idx]), 64'(eb));
         end
      end
      tx_rd = tx_q.size();
   endtask

   task automatic expect_writes(input string name, input int base, input logic [31:0] words[$]);
      check({name, "_count"}, 64'(wr_q.size() - base), 64'(words.size()));
      for (int k = 0; k < words.size(); k++) begin
         if (base + k < wr_q.size()) begin
            check($sformatf("%s_addr%0d", name, k), 64'(wr_q[base+k].a), 64'(k % 1024));
            check($sformatf("%s_data%0d", name, k), 64'(wr_q[base+k].d), 64'(words[k]));
         end
      end
   endtask

   task automatic load_words(input logic [31:0] words[$], input logic [7:0] n_byte);
      send_byte(DBG_CMD_LOAD);
      send_byte(n_byte);
      foreach (words[k])
         for (int b = 0; b < 4; b++) send_byte(words[k][31-8*b -: 8]);
      repeat (10) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic       exp_debug;
      int         exp_tx;
      int         exp_steps;
      int         mode;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [31:0] words[$];
      int w0, s0, t0, n;
      logic [7:0] b;
      logic d0;

      for (int k = 0; k < 32; k++) regfile[k] = 32'(k);
      pc_val = 32'h0000_0008;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_debug", 64'(dbg), 64'd1);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_wren", 64'(wren), 64'd0);
      check("rst_step", 64'(step), 64'd0);
      check("rst_addr", 64'(addr_dbg), 64'd0);
      check("rst_data", 64'(data_dbg), 64'd0);
      check("rst_rfsel", 64'(rfsel), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_debug", 64'(dbg), 64'd1);
      check("post_rst_tx_valid", 64'(tx_valid), 64'd0);

      // Two-word load from the plan
      w0 = wr_q.size();
      words = '{32'h2001_0000, 32'hAC10_0004};
      load_words(words, 8'h02);
      expect_writes("load2", w0, words);

      // Command table
      vecs[0]  = '{DBG_CMD_STEP, 1'b1, DBG_DUMP_LEN, 1, 0};
      vecs[1]  = '{DBG_CMD_DUMP, 1'b1, DBG_DUMP_LEN, 0, 1};
      vecs[2]  = '{DBG_CMD_RUN,  1'b0, 0, 0, 0};
      vecs[3]  = '{DBG_CMD_STEP, 1'b0, 0, 0, 0};
      vecs[4]  = '{DBG_CMD_HALT, 1'b1, 0, 0, 0};
      vecs[5]  = '{8'h00,        1'b1, 0, 0, 0};
      vecs[6]  = '{DBG_CMD_RUN,  1'b0, 0, 0, 0};
      vecs[7]  = '{DBG_CMD_DUMP, 1'b0, DBG_DUMP_LEN, 0, 2};
      vecs[8]  = '{DBG_CMD_HALT, 1'b1, 0, 0, 0};
      vecs[9]  = '{DBG_CMD_STEP, 1'b1, DBG_DUMP_LEN, 1, 2};
      vecs[10] = '{8'hA5,        1'b1, 0, 0, 0};
      for (int i = 0; i < 11; i++) begin
         rdy_mode = vecs[i].mode;
         s0 = step_cnt;
         w0 = wr_q.size();
         send_byte(vecs[i].cmd);
         if (vecs[i].exp_tx != 0) begin
            expect_dump($sformatf("vec%0d", i), 3000);
         end else begin
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_tx", i), 64'(tx_q.size() - tx_rd), 64'd0);
         end
         check($sformatf("vec%0d_debug", i), 64'(dbg), 64'(vecs[i].exp_debug));
         check($sformatf("vec%0d_steps", i), 64'(step_cnt - s0), 64'(vecs[i].exp_steps));
         check($sformatf("vec%0d_wren", i), 64'(wr_q.size() - w0), 64'd0);
      end
      rdy_mode = 0;

      // Reset in the middle of a LOAD discards the partial word
      w0 = wr_q.size();
      send_byte(DBG_CMD_LOAD);
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midload_addr", 64'(addr_dbg), 64'd0);
      check("midload_debug", 64'(dbg), 64'd1);
      words = '{32'hDEAD_BEEF};
      load_words(words, 8'h01);
      expect_writes("reload", w0, words);

      // Random loads, last one with count 0 meaning 256 words
      for (int r = 0; r < 4; r++) begin
         n = (r == 3) ? 256 : int'($urandom_range(1, 6));
         words = {};
         for (int k = 0; k < n; k++) words.push_back($urandom);
         w0 = wr_q.size();
         load_words(words, 8'(n));
         expect_writes($sformatf("rload%0d", r), w0, words);
      end

      // Unknown command bytes are ignored
      d0 = dbg;
      s0 = step_cnt;
      w0 = wr_q.size();
      for (int j = 0; j < 8; j++) begin
         b = 8'($urandom_range(0, 250));
         if (b != 8'h00) b = b + 8'd5;
         send_byte(b);
      end
      repeat (10) @(negedge clk);
      check("junk_tx", 64'(tx_q.size() - tx_rd), 64'd0);
      check("junk_debug", 64'(dbg), 64'(d0));
      check("junk_steps", 64'(step_cnt - s0), 64'd0);
      check("junk_wren", 64'(wr_q.size() - w0), 64'd0);

      // Random register contents, random ready
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 32; k++) regfile[k] = $urandom;
         pc_val = $urandom;
         rdy_mode = 2;
         s0 = step_cnt;
         send_byte((r == 1) ? DBG_CMD_STEP : DBG_CMD_DUMP);
         expect_dump($sformatf("rdump%0d", r), 4000);
         check($sformatf("rdump%0d_steps", r), 64'(step_cnt - s0), 64'((r == 1) ? 1 : 0));
      end

      // Bytes arriving during a dump are dropped
      rdy_mode = 0;
      w0 = wr_q.size();
      send_byte(DBG_CMD_DUMP);
      send_byte(DBG_CMD_RUN);
      send_byte(DBG_CMD_LOAD);
      expect_dump("drop", 3000);
      check("drop_debug", 64'(dbg), 64'd1);
      check("drop_wren", 64'(wr_q.size() - w0), 64'd0);
      send_byte(DBG_CMD_RUN);
      repeat (3) @(negedge clk);
      check("drop_idle_run", 64'(dbg), 64'd0);
      send_byte(DBG_CMD_HALT);
      repeat (3) @(negedge clk);
      check("drop_idle_halt", 64'(dbg), 64'd1);

      // Ready held low stalls without loss
      rdy_mode = 3;
      t0 = tx_q.size();
      send_byte(DBG_CMD_DUMP);
      repeat (100) @(negedge clk);
      check("stall_valid", 64'(tx_valid), 64'd1);
      check("stall_data", 64'(tx_data), 64'(pc_val[31:24]));
      check("stall_count", 64'(tx_q.size() - t0), 64'd0);
      rdy_mode = 0;
      expect_dump("stall", 3000);

      // Asynchronous reset in the middle of a dump
      rdy_mode = 2;
      send_byte(DBG_CMD_DUMP);
      repeat (40) @(negedge clk);
      rdy_mode = 3;
      repeat (3) @(negedge clk);
      check("arst_pre_valid", 64'(tx_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(tx_valid), 64'd0);
      check("arst_debug", 64'(dbg), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      repeat (10) @(negedge clk);
      check("arst_after_valid", 64'(tx_valid), 64'd0);
      tx_rd = tx_q.size();
      send_byte(DBG_CMD_DUMP);
      expect_dump("arst_dump", 3000);

      check("tx_stable", 64'(stab_bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
